// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in clock cycles.
// Capture runs while startCAP is high. The first rising edge arms the block and every
// later edge publishes period/duty with a one-cycle valid strobe.
// Optional build macro PWM_CAPTURE_GLITCH_FILTER_EN adds a two-cycle agreement filter after
// the synchroniser, so single-cycle pulses are ignored and latency grows by one cycle.
module pwm_capture #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetPWM_n,
    input  logic             startCAP,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] duty,
    output logic             valid,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] CntOne = {{(WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

    state_e           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_level_prev;
    logic [WIDTH-1:0] r_per_cnt;
    logic [WIDTH-1:0] r_hi_cnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_duty;
    logic             r_valid;
    logic             r_overflow;

    state_e           w_state_nxt;
    logic [WIDTH-1:0] w_per_nxt;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_period_nxt;
    logic [WIDTH-1:0] w_duty_nxt;
    logic             w_valid_nxt;
    logic             w_ovf_nxt;
    logic             w_level;
    logic             w_edge;

    // Two-flop synchroniser plus the previous (filtered) level used for edge detection.
    always_ff @(posedge clock) begin
        if (!resetPWM_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_level_prev <= 1'b0;
        end else begin
            r_sync1      <= pwm_in;
            r_sync2      <= r_sync1;
            r_level_prev <= w_level;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic r_sync2_d;

    // Delayed sync2 so the filter can see two consecutive samples.
    always_ff @(posedge clock) begin
        if (!resetPWM_n) begin
            r_sync2_d <= 1'b0;
        end else begin
            r_sync2_d <= r_sync2;
        end
    end

    // Level follows sync2 only once two consecutive samples agree.
    assign w_level = (r_sync2 == r_sync2_d) ? r_sync2 : r_level_prev;
`else
    assign w_level = r_sync2;
`endif

    assign w_edge = w_level & ~r_level_prev;

    // Capture FSM and measurement registers.
    always_ff @(posedge clock) begin
        if (!resetPWM_n) begin
            r_state    <= StIdle;
            r_per_cnt  <= '0;
            r_hi_cnt   <= '0;
            r_period   <= '0;
            r_duty     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_per_cnt  <= w_per_nxt;
            r_hi_cnt   <= w_hi_nxt;
            r_period   <= w_period_nxt;
            r_duty     <= w_duty_nxt;
            r_valid    <= w_valid_nxt;
            r_overflow <= w_ovf_nxt;
        end
    end

    // Next-state logic; dropping startCAP overrides any edge seen in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_per_nxt    = r_per_cnt;
        w_hi_nxt     = r_hi_cnt;
        w_period_nxt = r_period;
        w_duty_nxt   = r_duty;
        w_valid_nxt  = 1'b0;
        w_ovf_nxt    = r_overflow;
        if (!startCAP) begin
            w_state_nxt = StIdle;
            w_per_nxt   = '0;
            w_hi_nxt    = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state_nxt = StArm;
                    w_per_nxt   = '0;
                    w_hi_nxt    = '0;
                end
                StArm: begin
                    // The arming edge starts a measurement but never reports one.
                    if (w_edge) begin
                        w_state_nxt = StMeasure;
                        w_per_nxt   = CntOne;
                        w_hi_nxt    = CntOne;
                    end else begin
                        w_per_nxt = '0;
                        w_hi_nxt  = '0;
                    end
                end
                StMeasure: begin
                    if (w_edge) begin
                        w_period_nxt = r_per_cnt;
                        w_duty_nxt   = r_hi_cnt;
                        w_valid_nxt  = 1'b1;
                        w_per_nxt    = CntOne;
                        w_hi_nxt     = CntOne;
                    end else if (r_per_cnt == CntMax) begin
                        // Period too long to represent: drop the partial result and re-arm.
                        w_state_nxt = StArm;
                        w_ovf_nxt   = 1'b1;
                        w_per_nxt   = '0;
                        w_hi_nxt    = '0;
                    end else begin
                        w_per_nxt = r_per_cnt + CntOne;
                        w_hi_nxt  = r_hi_cnt + {{(WIDTH - 1){1'b0}}, w_level};
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    assign period   = r_period;
    assign duty     = r_duty;
    assign valid    = r_valid;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: randomized and directed PWM stimulus checked against a
// timestamp-based reference model (period = distance between rising edges of the
// synchronised level, duty = number of high samples between them).
module tb_pwm_capture;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
    localparam int LAT0 = 14;
`else
    localparam bit FILT = 1'b0;
    localparam int LAT0 = 13;
`endif

    logic         clock;
    logic         resetPWM_n;
    logic         startCAP;
    logic         pwm_in;
    logic [W-1:0] period;
    logic [W-1:0] duty;
    logic         valid;
    logic         overflow;

    pwm_capture #(.WIDTH(W)) dut (
        .clock      (clock),
        .resetPWM_n (resetPWM_n),
        .startCAP   (startCAP),
        .pwm_in     (pwm_in),
        .period     (period),
        .duty       (duty),
        .valid      (valid),
        .overflow   (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: sample history s_h, filtered level history l_h, time of arming edge.
    int           n = 4;
    bit           s_h[8192];
    bit           l_h[8192];
    bit           m_idle = 1'b1;
    int           m_arm = -1;
    logic         m_valid = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W-1:0] m_period = '0;
    logic [W-1:0] m_duty = '0;

    task automatic tick();
        bit rise;
        int hi;
        @(posedge clock);
        n++;
        if (!resetPWM_n) begin
            for (int k = 0; k < 3; k++) begin
                s_h[n-k] = 1'b0;
                l_h[n-k] = 1'b0;
            end
            m_idle = 1'b1; m_arm = -1; m_valid = 1'b0; m_ovf = 1'b0;
            m_period = '0; m_duty = '0;
        end else begin
            s_h[n] = pwm_in;
            l_h[n] = FILT ? ((s_h[n] == s_h[n-1]) ? s_h[n] : l_h[n-1]) : s_h[n];
            rise = l_h[n-2] && !l_h[n-3];
            m_valid = 1'b0;
            if (!startCAP) begin
                m_idle = 1'b1; m_arm = -1; m_ovf = 1'b0;
            end else if (m_idle) begin
                m_idle = 1'b0; m_arm = -1;
            end else if (m_arm < 0) begin
                if (rise) m_arm = n;
            end else if (rise) begin
                hi = 0;
                for (int k = m_arm - 2; k <= n - 3; k++) hi += int'(l_h[k]);
                m_valid = 1'b1; m_period = W'(n - m_arm); m_duty = W'(hi); m_arm = n;
            end else if (n - m_arm >= MAX) begin
                m_ovf = 1'b1; m_arm = -1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        resetPWM_n = 1'b0; startCAP = 1'b1; pwm_in = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({valid, overflow, period, duty} !== 10'b0) begin
            n_err++;
            $display("FAIL reset: got v=%b o=%b p=%0d d=%0d, want all 0", valid, overflow, period, duty);
        end
        resetPWM_n = 1'b1; startCAP = 1'b0; pwm_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({valid, overflow, period, duty} !== 10'b0) begin
                n_err++;
                $display("FAIL reset_idle: got v=%b o=%b p=%0d d=%0d, want all 0", valid, overflow, period, duty);
            end
        end
    endtask

    task automatic test_basic();
        int ph = 0;
        int first = -1;
        startCAP = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            pwm_in = (ph < 5); ph = (ph + 1) % 10;
            tick();
            if (valid === 1'b1 && first < 0) first = i;
            n_cmp++;
            if ({valid, overflow, period, duty} !== {m_valid, m_ovf, m_period, m_duty}) begin
                n_err++;
                $display("FAIL basic: got v=%b o=%b p=%0d d=%0d, want v=%b o=%b p=%0d d=%0d",
                         valid, overflow, period, duty, m_valid, m_ovf, m_period, m_duty);
            end
        end
        n_cmp++;
        if (first != LAT0 || period !== 4'd10 || duty !== 4'd5) begin
            n_err++;
            $display("FAIL basic_first: got first=%0d p=%0d d=%0d, want first=%0d p=10 d=5",
                     first, period, duty, LAT0);
        end
    endtask

    task automatic test_duty_sweep();
        int ph = 0;
        for (int d = 5; d >= 1; d--) begin
            for (int i = 0; i < 30; i++) begin
                pwm_in = (ph < d); ph = (ph + 1) % 10;
                tick();
                n_cmp++;
                if ({valid, overflow, period, duty} !== {m_valid, m_ovf, m_period, m_duty}) begin
                    n_err++;
                    $display("FAIL sweep d%0d: got v=%b o=%b p=%0d d=%0d, want v=%b o=%b p=%0d d=%0d",
                             d, valid, overflow, period, duty, m_valid, m_ovf, m_period, m_duty);
                end
            end
        end
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
        n_cmp++;
        if ({overflow, period, duty} !== {1'b0, 4'd10, 4'd1}) begin
            n_err++;
            $display("FAIL sweep_end: got o=%b p=%0d d=%0d, want o=0 p=10 d=1", overflow, period, duty);
        end
`endif
    endtask

    task automatic test_overflow();
        logic [W-1:0] keep_p = m_period;
        logic [W-1:0] keep_d = m_duty;
        int nv = 0;
        startCAP = 1'b0; pwm_in = 1'b0;
        tick();
        startCAP = 1'b1;
        for (int i = 0; i < 25; i++) begin
            pwm_in = (i < 3);
            tick();
            if (valid === 1'b1) nv++;
            n_cmp++;
            if ({valid, overflow, period, duty} !== {m_valid, m_ovf, m_period, m_duty}) begin
                n_err++;
                $display("FAIL overflow: got v=%b o=%b p=%0d d=%0d, want v=%b o=%b p=%0d d=%0d",
                         valid, overflow, period, duty, m_valid, m_ovf, m_period, m_duty);
            end
        end
        n_cmp++;
        if (nv != 0 || overflow !== 1'b1 || period !== keep_p || duty !== keep_d) begin
            n_err++;
            $display("FAIL overflow_set: got valids=%0d o=%b p=%0d d=%0d, want 0 1 %0d %0d",
                     nv, overflow, period, duty, keep_p, keep_d);
        end
        startCAP = 1'b0;
        tick();
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_clear: got o=%b, want 0", overflow);
        end
        startCAP = 1'b1;
    endtask

    task automatic test_boundary();
        int ph = 0;
        for (int seg = 0; seg < 2; seg++) begin
            for (int i = 0; i < (seg == 0 ? 60 : 64); i++) begin
                pwm_in = (seg == 0) ? (ph < 14) : (ph < 8);
                ph = (ph + 1) % (seg == 0 ? 15 : 16);
                tick();
                n_cmp++;
                if ({valid, overflow, period, duty} !== {m_valid, m_ovf, m_period, m_duty}) begin
                    n_err++;
                    $display("FAIL boundary%0d: got v=%b o=%b p=%0d d=%0d, want v=%b o=%b p=%0d d=%0d",
                             seg, valid, overflow, period, duty, m_valid, m_ovf, m_period, m_duty);
                end
            end
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
            n_cmp++;
            if ({overflow, period, duty} !== {1'(seg), 4'd15, 4'd14}) begin
                n_err++;
                $display("FAIL boundary_end%0d: got o=%b p=%0d d=%0d, want o=%0d p=15 d=14",
                         seg, overflow, period, duty, seg);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        int ph = 0;
        startCAP = 1'b0; tick(); startCAP = 1'b1;
        for (int i = 0; i < 70; i++) begin
            resetPWM_n = (i != 26);
            pwm_in = (ph < 5); ph = (ph + 1) % 10;
            tick();
            if (i == 26) begin
                n_cmp++;
                if ({valid, overflow, period, duty} !== 10'b0) begin
                    n_err++;
                    $display("FAIL reset_mid: got v=%b o=%b p=%0d d=%0d, want all 0",
                             valid, overflow, period, duty);
                end
            end
            n_cmp++;
            if ({valid, overflow, period, duty} !== {m_valid, m_ovf, m_period, m_duty}) begin
                n_err++;
                $display("FAIL reset_run: got v=%b o=%b p=%0d d=%0d, want v=%b o=%b p=%0d d=%0d",
                         valid, overflow, period, duty, m_valid, m_ovf, m_period, m_duty);
            end
        end
        resetPWM_n = 1'b1;
    endtask

    task automatic test_glitch();
        int ph = 0;
        int n_short = 0;
        startCAP = 1'b0; tick(); startCAP = 1'b1;
        for (int i = 0; i < 60; i++) begin
            pwm_in = (ph < 5) || (ph == 7); ph = (ph + 1) % 10;
            tick();
            if (valid === 1'b1 && period !== 4'd10) n_short++;
            n_cmp++;
            if ({valid, overflow, period, duty} !== {m_valid, m_ovf, m_period, m_duty}) begin
                n_err++;
                $display("FAIL glitch: got v=%b o=%b p=%0d d=%0d, want v=%b o=%b p=%0d d=%0d",
                         valid, overflow, period, duty, m_valid, m_ovf, m_period, m_duty);
            end
        end
        n_cmp++;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        if (n_short != 0 || period !== 4'd10 || duty !== 4'd5) begin
            n_err++;
            $display("FAIL glitch_filtered: got short=%0d p=%0d d=%0d, want 0 10 5", n_short, period, duty);
        end
`else
        if (n_short == 0) begin
            n_err++;
            $display("FAIL glitch_unfiltered: got short=%0d, want nonzero", n_short);
        end
`endif
    endtask

    task automatic test_random();
        int ph = 0;
        int p, d, len, kind;
        for (int seg = 0; seg < 60; seg++) begin
            p = $urandom_range(17, 2); d = $urandom_range(p, 0);
            len = $urandom_range(60, 10); kind = $urandom_range(9, 0);
            ph = ph % p;
            for (int i = 0; i < len; i++) begin
                resetPWM_n = !(kind == 0 && i == len / 2);
                startCAP = !(kind == 1 && i == len / 2);
                pwm_in = (kind == 2) ? 1'($urandom_range(1, 0)) : (ph < d);
                ph = (ph + 1) % p;
                tick();
                n_cmp++;
                if ({valid, overflow, period, duty} !== {m_valid, m_ovf, m_period, m_duty}) begin
                    n_err++;
                    $display("FAIL random p%0d d%0d k%0d: got v=%b o=%b p=%0d d=%0d, want v=%b o=%b p=%0d d=%0d",
                             p, d, kind, valid, overflow, period, duty, m_valid, m_ovf, m_period, m_duty);
                end
            end
        end
        resetPWM_n = 1'b1; startCAP = 1'b1;
    endtask

    initial begin
        resetPWM_n = 1'b0; startCAP = 1'b0; pwm_in = 1'b0;
        test_reset();
        test_basic();
        test_duty_sweep();
        test_overflow();
        test_boundary();
        test_reset_mid();
        test_glitch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
